// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The producer/consumer side uses the master modport; the encoder uses the slave modport.
interface instr_encoder_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       imm_sel;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             imm_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, imm_sel, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, instr, imm_err, err_count
  );

  modport slave (
    input  in_valid, imm_sel, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, instr, imm_err, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32I fields and a 32-bit immediate into an instruction word, flagging immediates
// the selected format cannot hold. Two-stage valid/ready pipeline with a saturating error count.
module instr_encoder #(
  parameter bit          ERR_NOP = 1'b0,
  parameter int unsigned CNT_W   = 16
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);

  localparam logic [2:0]  SelI = 3'b000;
  localparam logic [2:0]  SelS = 3'b001;
  localparam logic [2:0]  SelB = 3'b010;
  localparam logic [2:0]  SelJ = 3'b011;
  localparam logic [2:0]  SelU = 3'b100;
  localparam logic [2:0]  SelR = 3'b101;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  // Stage 1: registered request fields plus the range-check verdict.
  logic        s1_valid_q;
  logic [2:0]  s1_sel_q;
  logic [6:0]  s1_opcode_q;
  logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]  s1_funct3_q;
  logic [6:0]  s1_funct7_q;
  logic [31:0] s1_imm_q;
  logic        s1_err_q;

  // Stage 2: output register.
  logic             out_valid_q;
  logic [31:0]      instr_q;
  logic             imm_err_q;
  logic [CNT_W-1:0] err_count_q;

  logic        s1_advance, in_fire, out_fire;
  logic        range_err;
  logic [31:0] packed_word, instr_d;

  assign s1_advance    = s1_valid_q & (~out_valid_q | bus.out_ready);
  assign bus.in_ready  = ~s1_valid_q | s1_advance;
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = out_valid_q & bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.instr     = instr_q;
  assign bus.imm_err   = imm_err_q;
  assign bus.err_count = err_count_q;

  // An immediate fits when every bit above the format's sign bit copies it.
  always_comb begin
    range_err = 1'b0;
    case (bus.imm_sel)
      SelI, SelS: range_err = ~((&bus.imm[31:11]) | ~(|bus.imm[31:11]));
      SelB:       range_err = bus.imm[0] | ~((&bus.imm[31:12]) | ~(|bus.imm[31:12]));
      SelJ:       range_err = bus.imm[0] | ~((&bus.imm[31:20]) | ~(|bus.imm[31:20]));
      SelU:       range_err = |bus.imm[11:0];
      SelR:       range_err = 1'b0;
      default:    range_err = 1'b1;
    endcase
  end

  always_comb begin
    packed_word = 32'h0;
    case (s1_sel_q)
      SelI: packed_word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      SelS: packed_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0],
                           s1_opcode_q};
      SelB: packed_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                           s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
      SelJ: packed_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                           s1_rd_q, s1_opcode_q};
      SelU: packed_word = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
      SelR: packed_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      default: packed_word = 32'h0;
    endcase
    instr_d = (ERR_NOP && s1_err_q) ? Nop : packed_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sel_q    <= 3'b0;
      s1_opcode_q <= 7'b0;
      s1_rd_q     <= 5'b0;
      s1_rs1_q    <= 5'b0;
      s1_rs2_q    <= 5'b0;
      s1_funct3_q <= 3'b0;
      s1_funct7_q <= 7'b0;
      s1_imm_q    <= 32'b0;
      s1_err_q    <= 1'b0;
    end else begin
      if (bus.in_ready) s1_valid_q <= bus.in_valid;
      if (in_fire) begin
        s1_sel_q    <= bus.imm_sel;
        s1_opcode_q <= bus.opcode;
        s1_rd_q     <= bus.rd;
        s1_rs1_q    <= bus.rs1;
        s1_rs2_q    <= bus.rs2;
        s1_funct3_q <= bus.funct3;
        s1_funct7_q <= bus.funct7;
        s1_imm_q    <= bus.imm;
        s1_err_q    <= range_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      instr_q     <= 32'b0;
      imm_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (s1_advance) begin
        out_valid_q <= 1'b1;
        instr_q     <= instr_d;
        imm_err_q   <= s1_err_q;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (out_fire && imm_err_q && (err_count_q != '1)) err_count_q <= err_count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench: two encoders (ERR_NOP off with 16-bit count, ERR_NOP on with 2-bit count)
// driven in lockstep from a vector table, plus backpressure and mid-stream reset sequences.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, out_ready;
  logic [2:0]  imm_sel;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;

  instr_encoder_if #(.CNT_W(16)) ifa ();
  instr_encoder_if #(.CNT_W(2))  ifb ();

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;
  assign ifa.imm_sel = imm_sel;    assign ifb.imm_sel = imm_sel;
  assign ifa.opcode = opcode;      assign ifb.opcode = opcode;
  assign ifa.rd = rd;              assign ifb.rd = rd;
  assign ifa.rs1 = rs1;            assign ifb.rs1 = rs1;
  assign ifa.rs2 = rs2;            assign ifb.rs2 = rs2;
  assign ifa.funct3 = funct3;      assign ifb.funct3 = funct3;
  assign ifa.funct7 = funct7;      assign ifb.funct7 = funct7;
  assign ifa.imm = imm;            assign ifb.imm = imm;

  instr_encoder #(.ERR_NOP(1'b0), .CNT_W(16)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  instr_encoder #(.ERR_NOP(1'b1), .CNT_W(2))  u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  typedef struct {
    logic [2:0]  sel;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] sel, input logic [6:0] opc,
                              input logic [4:0] rd_v, input logic [4:0] rs1_v,
                              input logic [4:0] rs2_v, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm_v,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.sel = sel; v.opc = opc; v.rd = rd_v; v.rs1 = rs1_v; v.rs2 = rs2_v;
    v.f3 = f3; v.f7 = f7; v.imm = imm_v; v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    imm_sel = v.sel; opcode = v.opc; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    apply(v);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifa.out_valid && n < 8);
    chk($sformatf("v%0d latency", idx), n, 2);
    chk($sformatf("v%0d instr_a", idx), ifa.instr, v.exp_instr);
    chk($sformatf("v%0d instr_b", idx), ifb.instr, v.exp_err ? 32'h0000_0013 : v.exp_instr);
    chk($sformatf("v%0d err_a", idx), ifa.imm_err, v.exp_err);
    chk($sformatf("v%0d err_b", idx), ifb.imm_err, v.exp_err);
    if (v.exp_err) exp_cnt++;
    @(negedge clk);
    chk($sformatf("v%0d drained", idx), ifa.out_valid, 0);
    chk($sformatf("v%0d cnt_a", idx), ifa.err_count, exp_cnt);
    chk($sformatf("v%0d cnt_b", idx), ifb.err_count, (exp_cnt > 3) ? 3 : exp_cnt);
  endtask

  vec_t vecs[18];
  vec_t w[3];
  logic [31:0] w_exp[3];
  logic [31:0] got[$];

  initial begin
    int k;
    logic rdy, ov;
    logic [31:0] oi;

    vecs[0]  = mk(3'b000, 7'h13, 5'd1, 5'd0, 5'd7, 3'd0, 7'h7F, 32'hFFFF_FFFF, 32'hFFF0_0093, 0);
    vecs[1]  = mk(3'b001, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h0, 32'h0000_0008, 32'h0020_A423, 0);
    vecs[2]  = mk(3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 0);
    vecs[3]  = mk(3'b011, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0000_0800, 32'h0010_00EF, 0);
    vecs[4]  = mk(3'b100, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h1234_5000, 32'h1234_52B7, 0);
    vecs[5]  = mk(3'b000, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0000_0800, 32'h8000_0013, 1);
    vecs[6]  = mk(3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0000_0006, 32'h0000_0363, 0);
    vecs[7]  = mk(3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0000_0003, 32'h0000_0163, 1);
    vecs[8]  = mk(3'b111, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0000_0000, 32'h0000_0000, 1);
    vecs[9]  = mk(3'b101, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4031_00B3, 0);
    vecs[10] = mk(3'b000, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'hFFFF_F800, 32'h8000_0013, 0);
    vecs[11] = mk(3'b000, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0000_07FF, 32'h7FF0_0013, 0);
    vecs[12] = mk(3'b011, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'hFFF0_0000, 32'h8000_006F, 0);
    vecs[13] = mk(3'b011, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0010_0000, 32'h8000_006F, 1);
    vecs[14] = mk(3'b100, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0000_1001, 32'h0000_1037, 1);
    vecs[15] = mk(3'b001, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'hFFFF_F7FF, 32'h7E00_0FA3, 1);
    vecs[16] = mk(3'b110, 7'h33, 5'd3, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0000_0000, 32'h0000_0000, 1);
    vecs[17] = mk(3'b011, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0000_0801, 32'h0010_00EF, 1);

    for (int i = 0; i < 3; i++) begin
      w[i] = mk(3'b000, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'h0, 32'(i + 10), 32'h0, 0);
      w_exp[i] = (32'(i + 10) << 20) | (32'(i + 1) << 7) | 32'h13;
    end

    in_valid = 1'b0; out_ready = 1'b1;
    apply(vecs[0]);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", ifa.out_valid, 0);
    chk("rst instr", ifa.instr, 0);
    chk("rst imm_err", ifa.imm_err, 0);
    chk("rst err_count", ifa.err_count, 0);
    chk("rst in_ready", ifa.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

    // Backpressure: hold the sink off for 5 cycles while offering 3 words.
    @(negedge clk);
    out_ready = 1'b0;
    k = 0;
    rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (k < 3) begin apply(w[k]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      rdy = ifa.in_ready;
      if (c >= 2) begin
        chk($sformatf("bp hold valid c%0d", c), ifa.out_valid, 1);
        chk($sformatf("bp hold instr c%0d", c), ifa.instr, w_exp[0]);
      end
      @(posedge clk);
      if (rdy && in_valid) k++;
      @(negedge clk);
    end
    chk("bp accepts", k, 2);
    chk("bp in_ready low", rdy, 0);

    out_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      if (k < 3) begin apply(w[k]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      rdy = ifa.in_ready; ov = ifa.out_valid; oi = ifa.instr;
      @(posedge clk);
      if (rdy && in_valid) k++;
      if (ov) got.push_back(oi);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp count", got.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp word%0d", i), (i < got.size()) ? got[i] : 32'hXXXX_XXXX, w_exp[i]);

    // Mid-stream reset with both stages full.
    out_ready = 1'b0;
    apply(w[0]);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("pre-rst out_valid", ifa.out_valid, 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst out_valid_a", ifa.out_valid, 0);
    chk("midrst out_valid_b", ifb.out_valid, 0);
    chk("midrst cnt_a", ifa.err_count, 0);
    chk("midrst cnt_b", ifb.err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst idle c%0d", c), ifa.out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
